// File: rtl/piso_pkg.sv
// Shared definitions for the piso_tx parallel-in serial-out transmitter.
// Optional feature macro: PISO_PARITY_EN (appends an even-parity bit to
// every frame when defined).
package piso_pkg;

    // FSM encoding shared by the design and anything that observes dbg_state.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } piso_state_e;

    // Widest word the parity helper can fold; callers zero-extend into it.
    localparam int MAX_W = 64;

    // Serial frame length in clocks for an n-bit data word.
    function automatic int frame_len(input int n);
`ifdef PISO_PARITY_EN
        return n + 1;
`else
        return n;
`endif
    endfunction

    // Even parity: XOR of all data bits, so data plus parity has an even
    // number of ones. Zero extension does not change the result.
    function automatic logic even_parity(input logic [MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/piso_tx_if.sv
// Producer-side word handshake and serial output bundle of piso_tx.
//
// Handshake: a word on `a` is transferred at every rising clk edge where
// in_valid && in_ready. The producer keeps in_valid and a stable until that
// edge; in_ready may drop at any time and no word is lost while it is low.
interface piso_tx_if #(
    parameter int N = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [N-1:0]             a;
    logic                     sout;
    logic                     sout_valid;
    logic                     sof;
    logic                     busy;
    piso_pkg::piso_state_e    dbg_state;

    modport master (
        output in_valid, a,
        input  in_ready, sout, sout_valid, sof, busy, dbg_state
    );

    modport slave (
        input  in_valid, a,
        output in_ready, sout, sout_valid, sof, busy, dbg_state
    );
endinterface

// File: rtl/piso_hold_buf.sv
// One-entry holding register for piso_tx. Keeps the next word while the
// shifter is busy so consecutive frames can follow without a gap.
module piso_hold_buf #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         unload,
    input  logic [N-1:0] d,
    output logic [N-1:0] q,
    output logic         full,
    output logic         in_ready
);

    // A load wins over a simultaneous unload: the slot is refilled at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q    <= '0;
            full <= 1'b0;
        end else if (load) begin
            q    <= d;
            full <= 1'b1;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

    // Space available exactly when the slot is empty.
    assign in_ready = !full;

endmodule

// File: rtl/piso_tx.sv
// piso_tx: accepts N-bit words over valid/ready and sends them one bit per
// clock, registered, with sof marking the first bit of each frame.
// Optional feature macro: PISO_PARITY_EN (adds an even-parity bit per frame).
module piso_tx
    import piso_pkg::*;
#(
    parameter int N         = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic      clk,
    input  logic      rst,
    piso_tx_if.slave  bus
);

    localparam int             L    = frame_len(N);
    localparam int             CW   = $clog2(L);
    localparam logic [CW-1:0]  LAST = CW'(L - 1);

    piso_state_e   state;
    logic [N-1:0]  shreg;
    logic [CW-1:0] cnt;
    logic          sout_r;
    logic          sout_valid_r;
    logic          sof_r;
`ifdef PISO_PARITY_EN
    logic          par;
`endif

    logic [N-1:0]  hold_q;
    logic          hold_full;
    logic          hold_ready;
    logic          accept;
    logic          last_edge;
    logic          direct_load;
    logic          hold_load;
    logic          hold_unload;
    logic          load_en;
    logic [N-1:0]  load_word;

    // Bit that sits at the output end of a word.
    function automatic logic out_bit(input logic [N-1:0] w);
        return MSB_FIRST ? w[N-1] : w[0];
    endfunction

    // Word advanced by one position toward the output end.
    function automatic logic [N-1:0] shift_word(input logic [N-1:0] w);
        return MSB_FIRST ? {w[N-2:0], 1'b0} : {1'b0, w[N-1:1]};
    endfunction

    assign accept      = bus.in_valid && hold_ready;
    assign last_edge   = (state == ST_SHIFT) && (cnt == LAST);
    // A word goes straight to the shifter when it is free at this edge,
    // otherwise it parks in the holding register.
    assign direct_load = accept && ((state == ST_IDLE) || (last_edge && !hold_full));
    assign hold_load   = accept && !direct_load;
    assign hold_unload = last_edge && hold_full;
    assign load_en     = direct_load || hold_unload;
    assign load_word   = hold_unload ? hold_q : bus.a;

    piso_hold_buf #(.N(N)) u_hold (
        .clk      (clk),
        .rst      (rst),
        .load     (hold_load),
        .unload   (hold_unload),
        .d        (bus.a),
        .q        (hold_q),
        .full     (hold_full),
        .in_ready (hold_ready)
    );

    // Frame FSM: loading puts the first bit on sout immediately, so the
    // shift register keeps only the bits still to be sent.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            shreg        <= '0;
            cnt          <= '0;
            sout_r       <= 1'b0;
            sout_valid_r <= 1'b0;
            sof_r        <= 1'b0;
`ifdef PISO_PARITY_EN
            par          <= 1'b0;
`endif
        end else if (load_en) begin
            state        <= ST_SHIFT;
            shreg        <= shift_word(load_word);
            cnt          <= '0;
            sout_r       <= out_bit(load_word);
            sout_valid_r <= 1'b1;
            sof_r        <= 1'b1;
`ifdef PISO_PARITY_EN
            par          <= even_parity(MAX_W'(load_word));
`endif
        end else if (state == ST_SHIFT && !last_edge) begin
            shreg  <= shift_word(shreg);
            cnt    <= cnt + 1'b1;
            sof_r  <= 1'b0;
`ifdef PISO_PARITY_EN
            if (cnt == CW'(N - 1)) begin
                sout_r <= par;
            end else begin
                sout_r <= out_bit(shreg);
            end
`else
            sout_r <= out_bit(shreg);
`endif
        end else if (last_edge) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            sout_r       <= 1'b0;
            sout_valid_r <= 1'b0;
            sof_r        <= 1'b0;
        end
    end

    assign bus.in_ready   = hold_ready;
    assign bus.sout       = sout_r;
    assign bus.sout_valid = sout_valid_r;
    assign bus.sof        = sof_r;
    assign bus.busy       = (state == ST_SHIFT) || hold_full;
    assign bus.dbg_state  = state;

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx: an MSB-first instance carries most
// scenarios, an LSB-first instance covers bit order. Honours PISO_PARITY_EN.
module tb_piso_tx;
    import piso_pkg::*;

    localparam int N = 4;
    localparam int L = frame_len(N);

`ifdef PISO_PARITY_EN
    localparam logic [14:0] EXP_SINGLE = 15'b10111;
    localparam logic [14:0] EXP_B2B    = 15'b10100_01010_11110;
    localparam logic [14:0] EXP_LSB    = 15'b10001;
`else
    localparam logic [14:0] EXP_SINGLE = 15'b1011;
    localparam logic [14:0] EXP_B2B    = 15'hA5F;
    localparam logic [14:0] EXP_LSB    = 15'b1000;
`endif
    localparam logic [14:0] FMASK  = 15'((1 << L) - 1);
    localparam logic [14:0] FMASK3 = 15'((1 << (3 * L)) - 1);

    logic clk = 1'b0;
    logic rst = 1'b0;

    piso_tx_if #(.N(N)) v0 ();
    piso_tx_if #(.N(N)) v1 ();

    piso_tx #(.N(N), .MSB_FIRST(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(v0.slave));
    piso_tx #(.N(N), .MSB_FIRST(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(v1.slave));

    // Clock
    always #5 clk = ~clk;

    logic [1:0]  exp_q0[$];
    logic [1:0]  exp_q1[$];
    int          errors = 0;
    int          checks = 0;
    int          run0 = 0;
    int          last_run0 = 0;
    int          sof_cnt0 = 0;
    logic [14:0] cap0 = '0;
    logic [14:0] cap1 = '0;

    // Scoreboard for the MSB-first instance: every frame bit pops {sof, bit}.
    initial begin
        logic [1:0] e;
        forever begin
            @(negedge clk);
            if (rst && v0.sout_valid) begin
                run0++;
                cap0 = {cap0[13:0], v0.sout};
                if (v0.sof) sof_cnt0++;
                checks++;
                if (exp_q0.size() == 0) begin
                    errors++;
                    $display("FAIL mon0_extra: got sof=%0b bit=%0b, required no frame bit", v0.sof, v0.sout);
                end else begin
                    e = exp_q0.pop_front();
                    if ({v0.sof, v0.sout} !== e) begin
                        errors++;
                        $display("FAIL mon0_bit: got sof,bit=%b, required %b", {v0.sof, v0.sout}, e);
                    end
                end
            end else begin
                if (run0 != 0) last_run0 = run0;
                run0 = 0;
            end
        end
    end

    // Scoreboard for the LSB-first instance.
    initial begin
        logic [1:0] e;
        forever begin
            @(negedge clk);
            if (rst && v1.sout_valid) begin
                cap1 = {cap1[13:0], v1.sout};
                checks++;
                if (exp_q1.size() == 0) begin
                    errors++;
                    $display("FAIL mon1_extra: got sof=%0b bit=%0b, required no frame bit", v1.sof, v1.sout);
                end else begin
                    e = exp_q1.pop_front();
                    if ({v1.sof, v1.sout} !== e) begin
                        errors++;
                        $display("FAIL mon1_bit: got sof,bit=%b, required %b", {v1.sof, v1.sout}, e);
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push0(input logic [N-1:0] w);
        for (int i = 0; i < N; i++) exp_q0.push_back({(i == 0), w[N-1-i]});
`ifdef PISO_PARITY_EN
        exp_q0.push_back({1'b0, ^w});
`endif
    endtask

    task automatic push1(input logic [N-1:0] w);
        for (int i = 0; i < N; i++) exp_q1.push_back({(i == 0), w[i]});
`ifdef PISO_PARITY_EN
        exp_q1.push_back({1'b0, ^w});
`endif
    endtask

    // Offer a word on v0 and hold it until accepted; reports stall cycles.
    task automatic send0(input logic [N-1:0] w, output int stalls);
        stalls = 0;
        @(negedge clk);
        #1;
        v0.in_valid = 1'b1;
        v0.a        = w;
        while (!v0.in_ready && stalls < 100) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        if (stalls >= 100) begin
            checks++;
            errors++;
            $display("FAIL send0_timeout: in_ready stayed 0 for %0d cycles, required 1", stalls);
        end
        push0(w);
        @(posedge clk);
        #1;
        v0.in_valid = 1'b0;
    endtask

    task automatic wait_idle0();
        int t = 0;
        do begin
            @(negedge clk);
            #2;
            t++;
        end while ((v0.busy || v0.sout_valid) && t < 200);
        if (t >= 200) begin
            checks++;
            errors++;
            $display("FAIL idle0_timeout: busy=%0b sout_valid=%0b, required 0", v0.busy, v0.sout_valid);
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({v0.sout, v0.sout_valid, v0.sof, v0.busy} !== 4'b0000 || v0.dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_outputs: got sout,valid,sof,busy=%b state=%0d, required 0000 0",
                     {v0.sout, v0.sout_valid, v0.sof, v0.busy}, v0.dbg_state);
        end
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (v0.in_ready !== 1'b1 || v1.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b%b, required 11", v0.in_ready, v1.in_ready);
        end
    endtask

    task automatic test_single();
        int st;
        send0(4'b1011, st);
        @(negedge clk);
        #2;
        checks++;
        if ({v0.sout_valid, v0.sof, v0.sout} !== 3'b111) begin
            errors++;
            $display("FAIL single_latency: got valid,sof,bit=%b, required 111", {v0.sout_valid, v0.sof, v0.sout});
        end
        wait_idle0();
        checks++;
        if (last_run0 != L) begin
            errors++;
            $display("FAIL single_len: got %0d valid cycles, required %0d", last_run0, L);
        end
        checks++;
        if ((cap0 & FMASK) !== EXP_SINGLE) begin
            errors++;
            $display("FAIL single_bits: got %b, required %b", cap0 & FMASK, EXP_SINGLE);
        end
        checks++;
        if (v0.busy !== 1'b0 || exp_q0.size() != 0) begin
            errors++;
            $display("FAIL single_done: got busy=%0b pending=%0d, required 0 0", v0.busy, exp_q0.size());
        end
    endtask

    task automatic test_back_to_back();
        int st_a, st_5, st_f;
        int base;
        base = sof_cnt0;
        send0(4'hA, st_a);
        send0(4'h5, st_5);
        send0(4'hF, st_f);
        checks++;
        if (st_5 != 0) begin
            errors++;
            $display("FAIL b2b_hold_accept: got %0d stalls, required 0", st_5);
        end
        checks++;
        if (st_f != L - 1) begin
            errors++;
            $display("FAIL b2b_stall: got %0d stalls, required %0d", st_f, L - 1);
        end
        wait_idle0();
        checks++;
        if (last_run0 != 3 * L) begin
            errors++;
            $display("FAIL b2b_contiguous: got %0d valid cycles, required %0d", last_run0, 3 * L);
        end
        checks++;
        if ((cap0 & FMASK3) !== EXP_B2B) begin
            errors++;
            $display("FAIL b2b_bits: got %b, required %b", cap0 & FMASK3, EXP_B2B);
        end
        checks++;
        if (sof_cnt0 - base != 3) begin
            errors++;
            $display("FAIL b2b_sof: got %0d frame starts, required 3", sof_cnt0 - base);
        end
    endtask

    task automatic test_lsb();
        int t = 0;
        @(negedge clk);
        #1;
        v1.in_valid = 1'b1;
        v1.a        = 4'b0001;
        push1(4'b0001);
        @(posedge clk);
        #1;
        v1.in_valid = 1'b0;
        do begin
            @(negedge clk);
            #2;
            t++;
        end while ((v1.busy || v1.sout_valid) && t < 100);
        checks++;
        if ((cap1 & FMASK) !== EXP_LSB || t >= 100) begin
            errors++;
            $display("FAIL lsb_bits: got %b after %0d cycles, required %b", cap1 & FMASK, t, EXP_LSB);
        end
    endtask

`ifdef PISO_PARITY_EN
    task automatic test_parity();
        int st;
        send0(4'b0111, st);
        wait_idle0();
        checks++;
        if ((cap0 & FMASK) !== 15'b01111 || last_run0 != 5) begin
            errors++;
            $display("FAIL parity_odd: got %b len=%0d, required 01111 len=5", cap0 & FMASK, last_run0);
        end
        send0(4'b0011, st);
        wait_idle0();
        checks++;
        if ((cap0 & FMASK) !== 15'b00110 || last_run0 != 5) begin
            errors++;
            $display("FAIL parity_even: got %b len=%0d, required 00110 len=5", cap0 & FMASK, last_run0);
        end
    endtask
`endif

    task automatic test_reset_mid();
        int st;
        int seen = 0;
        send0(4'b1011, st);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({v0.sout, v0.sout_valid, v0.sof, v0.busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid: got sout,valid,sof,busy=%b, required 0000",
                     {v0.sout, v0.sout_valid, v0.sof, v0.busy});
        end
        exp_q0.delete();
        exp_q1.delete();
        @(negedge clk);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (v0.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_ready: got %b, required 1", v0.in_ready);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #2;
            if (v0.sout_valid || v0.busy) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_mid_quiet: got %0d active cycles, required 0", seen);
        end
    endtask

    task automatic test_stress();
        int st;
        int base;
        base = sof_cnt0;
        for (int i = 0; i < 10; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) @(negedge clk);
            send0(4'($urandom_range(0, 15)), st);
        end
        wait_idle0();
        checks++;
        if (sof_cnt0 - base != 10 || exp_q0.size() != 0) begin
            errors++;
            $display("FAIL stress_frames: got %0d frames pending=%0d, required 10 pending=0",
                     sof_cnt0 - base, exp_q0.size());
        end
    endtask

    initial begin
        v0.in_valid = 1'b0;
        v0.a        = '0;
        v1.in_valid = 1'b0;
        v1.a        = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_lsb();
`ifdef PISO_PARITY_EN
        test_parity();
`endif
        test_reset_mid();
        test_stress();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/piso_tx.md
Name: piso_tx

Overview:
- Parallel-in serial-out transmitter; the serializing counterpart to the team's parallel/serial-in shift registers.
- Accepts N-bit words over a valid/ready handshake and emits them one bit per clock with a frame-start marker.
- A one-entry holding buffer allows gap-free back-to-back words.
- Sits between a parallel producer and a serial link, or a SIPO receiver under test.

Parameters:
- N, 4, data word width in bits (N >= 2).
- MSB_FIRST, 1, 1 = bit N-1 shifted out first; 0 = bit 0 first.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- in_valid  input  1  producer has a word on a.
- in_ready  output  1  transmitter can accept a word this cycle.
- a  input  N  parallel data word; sampled on accept.
- sout  output  1  serial data bit, registered.
- sout_valid  output  1  sout carries a frame bit this cycle.
- sof  output  1  high on the first bit of each frame only.
- busy  output  1  shifter active or holding buffer occupied.

Behaviour:
- Reset (rst=0, async): state=IDLE, shreg=0, cnt=0, hold_full=0, sout=0, sout_valid=0, sof=0, busy=0. in_ready is 1 once rst=1.
- Accept: in_valid && in_ready at a rising edge. in_ready = !hold_full (combinational). in_valid may be held; no data is lost while in_ready=0.
- FSM states:
  - IDLE: sout_valid=0, sout=0. On accept: load shreg with a, cnt=0, go to SHIFT. First bit appears on sout in the cycle after the accepting edge (latency 1). sof=1 for that bit.
  - SHIFT: each edge with cnt < L-1: shift shreg toward the output end, cnt++, sof=0. L is the frame length (N, or N+1 with parity).
- Last-bit edge (cnt == L-1):
  - If hold_full: hold moves into shreg, cnt=0, sof=1, hold_full=0.
  - Else if accept on that edge: a loads directly into shreg, cnt=0, sof=1.
  - Else: go to IDLE; sout_valid=0 next cycle.
- Accept in SHIFT before the last bit: a goes to the holding register, hold_full=1.
- Accept on the last-bit edge with hold_full=1: hold moves to shreg and the new word enters hold (hold_full stays 1).
- Back-to-back words produce a continuous sout_valid with no idle cycle.
- Bit order: MSB_FIRST=1 emits a[N-1] down to a[0]; MSB_FIRST=0 emits a[0] up to a[N-1].
- cnt width: clog2(L).
- busy = (state==SHIFT) || hold_full.
- Reset mid-frame aborts the frame immediately; the partial word and the held word are discarded.

Optional Feature:
- Macro PISO_PARITY_EN.
- Defined: L = N+1. After the N data bits, one extra bit carries even parity, i.e. XOR of the N data bits. sout_valid stays high for it; sof behaviour is unchanged. Parity is computed at load time and stored alongside shreg.
- Undefined: L = N, no parity logic or storage.

Decomposition:
- Shared package/include piso_pkg:
  - state encoding localparams ST_IDLE=1'b0, ST_SHIFT=1'b1.
  - even-parity function.
  - frame-length constant expression.
- One natural sub-module: piso_hold_buf, the one-entry holding register with a full flag, load/unload strobes and in_ready generation.

Test Plan:
- Reset: drive rst=0 during bit 2 of a frame -> sout, sout_valid, sof and busy read 0 within the same cycle; in_ready=1 after rst=1; no further bits emitted.
- Single word, N=4, MSB_FIRST=1, a=4'b1011 -> sout 1,0,1,1 on 4 consecutive cycles starting 1 cycle after accept; sof only on the first; then sout_valid=0 and busy=0.
- Back-to-back: a=4'hA then 4'h5 with in_valid held -> 8 contiguous valid bits 1010 0101; sof on bits 1 and 5. A third word 4'hF is stalled (in_ready=0) until 4'h5 moves to shreg, then follows gap-free.
- LSB first, MSB_FIRST=0, a=4'b0001 -> sout 1,0,0,0.
- With PISO_PARITY_EN, a=4'b0111 -> sout 0,1,1,1,1 (parity bit 1), 5 valid cycles. a=4'b0011 -> parity bit 0.
- Random stress: 10 random words with random in_valid gaps -> the serial stream reassembles to exactly the accepted words, in order, with no duplicates or drops.
